// File: rtl/dctq_zigzag_rle.sv
// Zigzag reorder of 8x8 quantised DCT blocks through a ping-pong buffer, followed by
// (run, level) run-length tokenisation with an end-of-block token per block.
module dctq_zigzag_rle #(
    parameter int DW    = 9,
    parameter int RUNW  = 6,
    parameter int ZZ_EN = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [DW-1:0]   dctq,
    input  logic            dctq_valid,
    input  logic [5:0]      addr,
    output logic            hold,
    output logic            rle_valid,
    input  logic            rle_ready,
    output logic [RUNW-1:0] rle_run,
    output logic [DW-1:0]   rle_level,
    output logic            rle_eob,
    output logic            overflow
);
    typedef enum logic [2:0] {IDLE, DC, SCAN, EMIT, EOB} state_t;

    // Raster index -> zigzag position, walking anti-diagonals s = row+col.
    function automatic logic [5:0] zz_pos(input logic [5:0] a);
        int r, c, s, b, o;
        r = int'(a[5:3]);
        c = int'(a[2:0]);
        s = r + c;
        if (s < 8) begin
            b = (s * (s + 1)) / 2;
            o = (s % 2 == 1) ? r : c;
        end else begin
            b = 64 - ((15 - s) * (16 - s)) / 2;
            o = (s % 2 == 1) ? r - (s - 7) : 7 - r;
        end
        return 6'(b + o);
    endfunction

    logic [DW-1:0] mem [0:127];
    logic [DW-1:0] rd_data;
    logic [1:0]    full, full_n;
    logic          wr_bank, wr_bank_n, rd_bank, rd_bank_n;
    logic [5:0]    cnt, cnt_n, wr_pos;
    logic          wr_en, ovf_set, free;

    state_t          state, state_n;
    logic [5:0]      idx, idx_n, rd_idx;
    logic [RUNW-1:0] run_cnt, run_n, r_n;
    logic [DW-1:0]   l_n;
    logic            last, last_n, v_n, e_n, rd_en;

    assign wr_pos = (ZZ_EN != 0) ? zz_pos(addr) : addr;

    // Write side; a beat is judged against the full flag as it stood before this edge.
    always_comb begin
        full_n    = full;
        wr_bank_n = wr_bank;
        cnt_n     = cnt;
        wr_en     = 1'b0;
        ovf_set   = 1'b0;
        if (dctq_valid) begin
            if (full[wr_bank]) begin
                ovf_set = 1'b1;
            end else begin
                wr_en = 1'b1;
                if (cnt == 6'd63) begin
                    full_n[wr_bank] = 1'b1;
                    wr_bank_n       = ~wr_bank;
                    cnt_n           = 6'd0;
                end else begin
                    cnt_n = cnt + 6'd1;
                end
            end
        end
        if (free) full_n[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full     <= 2'b00;
            wr_bank  <= 1'b0;
            cnt      <= 6'd0;
            overflow <= 1'b0;
            hold     <= 1'b0;
        end else begin
            full     <= full_n;
            wr_bank  <= wr_bank_n;
            cnt      <= cnt_n;
            overflow <= overflow | ovf_set;
            hold     <= full_n[wr_bank_n];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[{wr_bank, wr_pos}] <= dctq;
        if (rd_en) rd_data <= mem[{rd_bank, rd_idx}];
    end

    // rd_data always holds coef[idx], not yet examined; it is frozen during EMIT so a
    // stall neither skips nor repeats an index.
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        run_n     = run_cnt;
        last_n    = last;
        v_n       = rle_valid;
        r_n       = rle_run;
        l_n       = rle_level;
        e_n       = rle_eob;
        rd_en     = 1'b0;
        rd_idx    = idx;
        free      = 1'b0;
        rd_bank_n = rd_bank;
        case (state)
            IDLE: if (full[rd_bank]) begin
                rd_en   = 1'b1;
                rd_idx  = 6'd0;
                state_n = DC;
            end
            DC: begin
                v_n     = 1'b1;
                r_n     = '0;
                l_n     = rd_data;
                e_n     = 1'b0;
                rd_en   = 1'b1;
                rd_idx  = 6'd1;
                idx_n   = 6'd1;
                run_n   = '0;
                last_n  = 1'b0;
                state_n = EMIT;
            end
            SCAN: begin
                rd_en  = (idx != 6'd63);
                rd_idx = idx + 6'd1;
                idx_n  = (idx != 6'd63) ? idx + 6'd1 : idx;
                if (|rd_data) begin
                    v_n     = 1'b1;
                    r_n     = run_cnt;
                    l_n     = rd_data;
                    e_n     = 1'b0;
                    run_n   = '0;
                    last_n  = (idx == 6'd63);
                    state_n = EMIT;
                end else begin
                    run_n = run_cnt + RUNW'(1);
                    if (idx == 6'd63) begin
                        v_n     = 1'b1;
                        r_n     = '0;
                        l_n     = '0;
                        e_n     = 1'b1;
                        state_n = EOB;
                    end
                end
            end
            EMIT: if (rle_ready) begin
                if (last) begin
                    v_n     = 1'b1;
                    r_n     = '0;
                    l_n     = '0;
                    e_n     = 1'b1;
                    state_n = EOB;
                end else begin
                    v_n     = 1'b0;
                    state_n = SCAN;
                end
            end
            EOB: if (rle_ready) begin
                free      = 1'b1;
                rd_bank_n = ~rd_bank;
                v_n       = 1'b0;
                e_n       = 1'b0;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= 6'd0;
            run_cnt   <= '0;
            last      <= 1'b0;
            rd_bank   <= 1'b0;
            rle_valid <= 1'b0;
            rle_run   <= '0;
            rle_level <= '0;
            rle_eob   <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            run_cnt   <= run_n;
            last      <= last_n;
            rd_bank   <= rd_bank_n;
            rle_valid <= v_n;
            rle_run   <= r_n;
            rle_level <= l_n;
            rle_eob   <= e_n;
        end
    end
endmodule

// File: tb/tb_dctq_zigzag_rle.sv
// Scoreboard bench for dctq_zigzag_rle: directed blocks, expected tokens queued at issue
// time and checked by an independent monitor on every accepted token.
module tb_dctq_zigzag_rle;
    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] dctq;
    logic       dctq_valid;
    logic [5:0] addr;
    logic       hold, rle_valid, rle_ready, rle_eob, overflow;
    logic [5:0] rle_run;
    logic [8:0] rle_level;

    dctq_zigzag_rle #(.DW(9), .RUNW(6), .ZZ_EN(1)) dut (
        .clk(clk), .reset(reset), .dctq(dctq), .dctq_valid(dctq_valid), .addr(addr),
        .hold(hold), .rle_valid(rle_valid), .rle_ready(rle_ready), .rle_run(rle_run),
        .rle_level(rle_level), .rle_eob(rle_eob), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int          nvec = 0;
    int          nbad = 0;
    logic [15:0] exp_q[$];
    logic [8:0]  blk [64];
    logic [15:0] tok;
    logic        stall_prev = 1'b0;
    logic [15:0] stall_tok;

    assign tok = {rle_eob, rle_run, rle_level};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: tokens transfer on the next rising edge when valid&ready at the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                nvec++;
                if (!rle_valid || tok !== stall_tok) begin
                    nbad++;
                    $display("FAIL stall_stable: got v=%0b tok=%h expected v=1 tok=%h",
                             rle_valid, tok, stall_tok);
                end
            end
            if (rle_valid && rle_ready) begin
                nvec++;
                if (exp_q.size() == 0) begin
                    nbad++;
                    $display("FAIL token: got unexpected tok=%h expected none", tok);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    if (tok !== e) begin
                        nbad++;
                        $display("FAIL token: got eob=%0b run=%0d lvl=%h expected eob=%0b run=%0d lvl=%h",
                                 tok[15], tok[14:9], tok[8:0], e[15], e[14:9], e[8:0]);
                    end
                end
            end
            stall_prev = rle_valid && !rle_ready;
            stall_tok  = tok;
        end
    end

    task automatic push(input logic e, input logic [5:0] r, input logic [8:0] l);
        exp_q.push_back({e, r, l});
    endtask

    task automatic clear_blk();
        for (int i = 0; i < 64; i++) blk[i] = 9'd0;
    endtask

    task automatic send_beats(input int n, input int stride);
        for (int i = 0; i < n; i++) begin
            int a;
            a = (i * stride) % 64;
            dctq_valid = 1'b1;
            addr       = 6'(a);
            dctq       = blk[a];
            @(posedge clk); #1;
        end
        dctq_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin tick(1); n++; end
        chk(name, exp_q.size(), 0);
        tick(4);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; dctq_valid = 1'b0; dctq = '0; addr = '0; rle_ready = 1'b1;
        tick(3);
        reset = 1'b0;
        chk("rst_valid", rle_valid, 0);
        chk("rst_tok", tok, 0);
        chk("rst_hold", hold, 0);
        chk("rst_ovf", overflow, 0);

        // 1: all-zero block -> DC(0) and EOB only
        clear_blk();
        push(0, 0, 0); push(1, 0, 0);
        send_beats(64, 1);
        chk("t1_hold", hold, 0);
        wait_drain("t1_drain");
        chk("t1_hold_end", hold, 0);

        // 2: DC=5, raster2 (zz5) = -3, scrambled beat order; DC valid 3 cycles after last beat
        clear_blk(); blk[0] = 9'd5; blk[2] = 9'h1FD;
        push(0, 0, 9'd5); push(0, 4, 9'h1FD); push(1, 0, 0);
        send_beats(64, 5);
        chk("t2_dc_t1", rle_valid, 0);
        tick(1); chk("t2_dc_t2", rle_valid, 0);
        tick(1); chk("t2_dc_t3", rle_valid, 1);
        wait_drain("t2_drain");

        // 3: only raster63 nonzero -> maximum run
        clear_blk(); blk[63] = 9'd1;
        push(0, 0, 0); push(0, 62, 9'd1); push(1, 0, 0);
        send_beats(64, 1);
        wait_drain("t3_drain");

        // 7: several zigzag positions, including -256 at the last index
        clear_blk(); blk[1] = 9'h1FF; blk[8] = 9'd2; blk[9] = 9'd7; blk[57] = 9'd3; blk[63] = 9'h100;
        push(0, 0, 0); push(0, 0, 9'h1FF); push(0, 0, 9'd2); push(0, 1, 9'd7);
        push(0, 31, 9'd3); push(0, 26, 9'h100); push(1, 0, 0);
        send_beats(64, 3);
        wait_drain("t7_drain");

        // 4: stall 10 cycles while (4,-3) is pending
        clear_blk(); blk[0] = 9'd5; blk[2] = 9'h1FD;
        push(0, 0, 9'd5); push(0, 4, 9'h1FD); push(1, 0, 0);
        send_beats(64, 1);
        begin
            int n = 0;
            while (!(rle_valid && !rle_eob && rle_run == 6'd4) && n < 100) begin tick(1); n++; end
            chk("t4_found", (n < 100), 1);
            rle_ready = 1'b0;
            tick(10);
            chk("t4_still", tok, {1'b0, 6'd4, 9'h1FD});
            rle_ready = 1'b1;
        end
        wait_drain("t4_drain");

        // 5: three blocks with downstream blocked; third overflows
        rle_ready = 1'b0;
        clear_blk(); blk[0] = 9'd5; blk[2] = 9'h1FD;
        push(0, 0, 9'd5); push(0, 4, 9'h1FD); push(1, 0, 0);
        send_beats(64, 1);
        chk("t5_hold1", hold, 0);
        clear_blk(); blk[63] = 9'd1;
        push(0, 0, 0); push(0, 62, 9'd1); push(1, 0, 0);
        send_beats(64, 1);
        chk("t5_hold2", hold, 1);
        chk("t5_ovf0", overflow, 0);
        for (int i = 0; i < 64; i++) blk[i] = 9'd7;
        send_beats(64, 1);
        chk("t5_ovf1", overflow, 1);
        chk("t5_hold3", hold, 1);
        rle_ready = 1'b1;
        wait_drain("t5_drain");
        chk("t5_hold_end", hold, 0);

        // 6: reset with a partial block in flight
        clear_blk();
        for (int i = 0; i < 64; i++) blk[i] = 9'd9;
        send_beats(30, 1);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        chk("t6_rst_valid", rle_valid, 0);
        chk("t6_rst_ovf", overflow, 0);
        tick(1);
        chk("t6_after_valid", rle_valid, 0);
        clear_blk(); blk[0] = 9'd5; blk[2] = 9'h1FD;
        push(0, 0, 9'd5); push(0, 4, 9'h1FD); push(1, 0, 0);
        send_beats(64, 1);
        wait_drain("t6_drain");
        chk("t6_ovf", overflow, 0);
        chk("t6_hold", hold, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
